// File: rtl/tlc_pkg.sv
// Shared definitions for the multiphase traffic-light controller.
//   - Lamp encodings driven onto each phase's 3-bit light field.
//   - Controller state type.
//   - lamp_code(): lamp value for one phase given controller state and ownership.
package tlc_pkg;

    localparam logic [2:0] GREEN  = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b001;

    typedef enum logic [1:0] {
        ALL_RED,
        GREEN_S,
        YELLOW_S
    } tlc_state_t;

    // Only the owning phase ever shows a non-red lamp.
    function automatic logic [2:0] lamp_code(input tlc_state_t st, input logic owner);
        logic [2:0] code;
        code = RED;
        if (owner) begin
            case (st)
                GREEN_S:  code = GREEN;
                YELLOW_S: code = YELLOW;
                default:  code = RED;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/tlc_multiphase_if.sv
// Bus between the debounced request inputs / lamp drivers and the controller.
//   ped_req       : pedestrian button level per phase (master -> slave)
//   preempt       : emergency preemption request level (master -> slave)
//   preempt_phase : phase to force green (master -> slave)
//   light         : per-phase lamp, phase i at [3i+2:3i] (slave -> master)
//   walk          : walk indication per phase (slave -> master)
//   active_phase  : phase owning green/yellow, last served during all-red (slave -> master)
//   ped_pending   : latched pedestrian demand (slave -> master)
interface tlc_multiphase_if #(
    parameter int NUM_PHASES = 3
);
    localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic [NUM_PHASES-1:0]   ped_req;
    logic                    preempt;
    logic [PW-1:0]           preempt_phase;
    logic [3*NUM_PHASES-1:0] light;
    logic [NUM_PHASES-1:0]   walk;
    logic [PW-1:0]           active_phase;
    logic [NUM_PHASES-1:0]   ped_pending;

    modport master (
        output ped_req, preempt, preempt_phase,
        input  light, walk, active_phase, ped_pending
    );

    modport slave (
        input  ped_req, preempt, preempt_phase,
        output light, walk, active_phase, ped_pending
    );

endinterface

// File: rtl/tlc_ped_latch.sv
// One-bit pedestrian request latch.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : debounced button level
//   green      : this phase currently shows green (requests are masked)
//   clr        : this phase is entering green on this clock edge
//   pending    : latched demand
// Clear has priority so a held button cannot re-arm on the entry edge; it
// re-latches only once the phase has left green.
module tlc_ped_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic green,
    input  logic clr,
    output logic pending
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (clr) begin
            pending <= 1'b0;
        end else if (req && !green) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/tlc_multiphase.sv
// N-phase signalised-intersection controller.
// Serves NUM_PHASES approaches round-robin (ALL_RED -> GREEN -> YELLOW),
// with pedestrian latches, timed walk, demand-driven gap-out and emergency
// preemption.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : tlc_multiphase_if.slave (requests in, lamps/walk/status out)
// All outputs are flopped; light/walk are registered from next-state values
// so they line up with the state register.
module tlc_multiphase
    import tlc_pkg::*;
#(
    parameter int NUM_PHASES   = 3,
    parameter int MIN_GREEN    = 10,
    parameter int MAX_GREEN    = 30,
    parameter int YELLOW_TIME  = 5,
    parameter int ALL_RED_TIME = 5,
    parameter int WALK_TIME    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    tlc_multiphase_if.slave bus
);

    localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam int TW = $clog2(MAX_GREEN + 1);

    localparam logic [TW-1:0] T_SAT      = TW'(MAX_GREEN);
    localparam logic [TW-1:0] G_MAX_LAST = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] G_MIN_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] Y_LAST     = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] AR_LAST    = TW'(ALL_RED_TIME - 1);
    localparam logic [TW-1:0] WALK_LIM   = TW'(WALK_TIME);
    localparam logic [PW-1:0] LAST_PH    = PW'(NUM_PHASES - 1);

    tlc_state_t              state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d, timer_inc, timer_eff;
    logic [PW-1:0]           phase_q, phase_d, rr_next;
    logic                    started_q, started_d;
    logic                    hold_q, hold_d;
    logic                    walk_en_q, walk_en_d;
    logic                    pre_pend_q, pre_pend_d;
    logic [PW-1:0]           pre_tgt_q, pre_tgt_d;
    logic                    enter_green, pre_entry;
    logic                    pre_valid, pre_on_active, demand_other;
    logic [NUM_PHASES-1:0]   ped_q, other_mask;
    logic [NUM_PHASES-1:0]   walk_d, walk_q;
    logic [3*NUM_PHASES-1:0] light_d, light_q;

    // Out-of-range targets are ignored entirely.
    assign pre_valid     = bus.preempt && (int'(bus.preempt_phase) < NUM_PHASES);
    assign pre_on_active = pre_valid && (bus.preempt_phase == phase_q);

    assign other_mask   = ~(NUM_PHASES'(1) << phase_q);
    assign demand_other = |(ped_q & other_mask);

    assign rr_next   = (phase_q >= LAST_PH) ? '0 : phase_q + PW'(1);
    // Saturate rather than wrap.
    assign timer_inc = (timer_q >= T_SAT) ? timer_q : timer_q + TW'(1);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_inc;
        phase_d     = phase_q;
        started_d   = started_q;
        hold_d      = hold_q;
        walk_en_d   = walk_en_q;
        pre_pend_d  = pre_pend_q;
        pre_tgt_d   = pre_tgt_q;
        enter_green = 1'b0;
        pre_entry   = 1'b0;
        // First cycle after a preempt hold is released counts as timer 0.
        timer_eff   = hold_q ? '0 : timer_q;

        // Remember the most recent valid target until the next green entry,
        // so the all-red exit serves it even if the request has dropped.
        if (pre_valid && !(state_q == GREEN_S && pre_on_active)) begin
            pre_pend_d = 1'b1;
            pre_tgt_d  = bus.preempt_phase;
        end

        case (state_q)
            ALL_RED: begin
                if (timer_q >= AR_LAST) begin
                    state_d     = GREEN_S;
                    timer_d     = '0;
                    enter_green = 1'b1;
                    started_d   = 1'b1;
                    pre_pend_d  = 1'b0;
                    pre_entry   = pre_valid || pre_pend_q;
                    if (pre_valid) begin
                        phase_d = bus.preempt_phase;
                    end else if (pre_pend_q) begin
                        phase_d = pre_tgt_q;
                    end else if (!started_q) begin
                        phase_d = '0;
                    end else begin
                        phase_d = rr_next;
                    end
                    hold_d    = pre_valid;
                    walk_en_d = ped_q[phase_d] && !pre_entry;
                end
            end
            GREEN_S: begin
                if (pre_on_active) begin
                    // Green held, timer frozen, walk suppressed for the rest of this green.
                    hold_d    = 1'b1;
                    timer_d   = timer_q;
                    walk_en_d = 1'b0;
                end else begin
                    hold_d  = 1'b0;
                    timer_d = hold_q ? TW'(1) : timer_inc;
                    if (pre_valid || (timer_eff >= G_MAX_LAST) ||
                        ((timer_eff >= G_MIN_LAST) && demand_other)) begin
                        state_d = YELLOW_S;
                        timer_d = '0;
                    end
                end
            end
            YELLOW_S: begin
                if (timer_q >= Y_LAST) begin
                    state_d = ALL_RED;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ALL_RED;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        light_d = '0;
        walk_d  = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            light_d[3*i +: 3] = lamp_code(state_d, phase_d == PW'(i));
            walk_d[i] = (phase_d == PW'(i)) && (state_d == GREEN_S) && walk_en_d &&
                        !hold_d && (timer_d < WALK_LIM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ALL_RED;
            timer_q    <= '0;
            phase_q    <= '0;
            started_q  <= 1'b0;
            hold_q     <= 1'b0;
            walk_en_q  <= 1'b0;
            pre_pend_q <= 1'b0;
            pre_tgt_q  <= '0;
            light_q    <= {NUM_PHASES{RED}};
            walk_q     <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            phase_q    <= phase_d;
            started_q  <= started_d;
            hold_q     <= hold_d;
            walk_en_q  <= walk_en_d;
            pre_pend_q <= pre_pend_d;
            pre_tgt_q  <= pre_tgt_d;
            light_q    <= light_d;
            walk_q     <= walk_d;
        end
    end

    for (genvar i = 0; i < NUM_PHASES; i++) begin : g_ped
        tlc_ped_latch u_latch (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (bus.ped_req[i]),
            .green   ((state_q == GREEN_S) && (phase_q == PW'(i))),
            .clr     (enter_green && (phase_d == PW'(i))),
            .pending (ped_q[i])
        );
    end

    assign bus.light        = light_q;
    assign bus.walk         = walk_q;
    assign bus.active_phase = phase_q;
    assign bus.ped_pending  = ped_q;

endmodule

// File: tb/tb_tlc_multiphase.sv
// Directed testbench for tlc_multiphase (3 phases, MIN 10, MAX 30, Y 5, AR 5, WALK 4).
module tb_tlc_multiphase;
    import tlc_pkg::*;

    localparam int NP = 3;
    localparam logic [3*NP-1:0] LAMPS_RED = {NP{RED}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    tlc_multiphase_if #(.NUM_PHASES(NP)) bus ();

    tlc_multiphase #(
        .NUM_PHASES(NP), .MIN_GREEN(10), .MAX_GREEN(30),
        .YELLOW_TIME(5), .ALL_RED_TIME(5), .WALK_TIME(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] lamp(input int ph);
        return bus.light[3*ph +: 3];
    endfunction

    // Invariant monitor, sampled on the falling edge.
    logic [3*NP-1:0] prev_light = LAMPS_RED;
    always @(negedge clk) begin : mon
        int nonred;
        logic [NP-1:0] gmask;
        logic g2r;
        if (!rst_n) begin
            prev_light = LAMPS_RED;
        end else begin
            nonred = 0;
            gmask  = '0;
            g2r    = 1'b0;
            for (int i = 0; i < NP; i++) begin
                if (bus.light[3*i +: 3] != RED) nonred++;
                gmask[i] = (bus.light[3*i +: 3] == GREEN);
                if (prev_light[3*i +: 3] == GREEN && bus.light[3*i +: 3] == RED) g2r = 1'b1;
            end
            n_checks++;
            if (nonred > 1) begin
                n_fail++; $display("FAIL mon_one_nonred: light=%b required at most one non-red", bus.light);
            end
            n_checks++;
            if (!$onehot0(bus.walk) || ((bus.walk & ~gmask) != '0)) begin
                n_fail++; $display("FAIL mon_walk: walk=%b light=%b required one-hot-or-zero on green", bus.walk, bus.light);
            end
            n_checks++;
            if (g2r) begin
                n_fail++; $display("FAIL mon_g2r: prev=%b now=%b required yellow between", prev_light, bus.light);
            end
            prev_light = bus.light;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.ped_req = '0;
        bus.preempt = 1'b0;
        bus.preempt_phase = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_color(input int ph, input logic [2:0] col, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (lamp(ph) == col) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic seg(input int ph, input logic [2:0] col, output int len,
                       output int wcnt, output int wlast, output bit ok);
        wait_color(ph, col, ok);
        len = 0; wcnt = 0; wlast = -1;
        while (ok && lamp(ph) == col && len < 1000) begin
            if (bus.walk[ph]) begin wcnt++; wlast = len; end
            len++;
            @(negedge clk);
        end
    endtask

    task automatic count_allred(output int len);
        len = 0;
        while (bus.light == LAMPS_RED && len < 1000) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ped_req = '1;
        bus.preempt = 1'b0;
        bus.preempt_phase = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.light !== LAMPS_RED) begin n_fail++; $display("FAIL rst_light: got %b expected %b", bus.light, LAMPS_RED); end
        n_checks++;
        if (bus.walk !== '0) begin n_fail++; $display("FAIL rst_walk: got %b expected 0", bus.walk); end
        n_checks++;
        if (bus.ped_pending !== '0) begin n_fail++; $display("FAIL rst_pending: got %b expected 0", bus.ped_pending); end
        n_checks++;
        if (bus.active_phase !== '0) begin n_fail++; $display("FAIL rst_active: got %0d expected 0", bus.active_phase); end
        bus.ped_req = '0;
    endtask

    task automatic test_free_run();
        int len, wc, wl;
        bit ok;
        do_reset();
        count_allred(len);
        n_checks++;
        if (len != 5) begin n_fail++; $display("FAIL free_first_ar: got %0d expected 5", len); end
        for (int k = 0; k < 4; k++) begin
            seg(k % NP, GREEN, len, wc, wl, ok);
            n_checks++;
            if (!ok || len != 30 || wc != 0) begin
                n_fail++; $display("FAIL free_green ph%0d: len %0d walk %0d expected 30/0", k % NP, len, wc);
            end
            seg(k % NP, YELLOW, len, wc, wl, ok);
            n_checks++;
            if (!ok || len != 5) begin n_fail++; $display("FAIL free_yellow ph%0d: got %0d expected 5", k % NP, len); end
            count_allred(len);
            n_checks++;
            if (len != 5) begin n_fail++; $display("FAIL free_allred ph%0d: got %0d expected 5", k % NP, len); end
        end
    endtask

    task automatic test_ped_gap();
        int len, wc, wl;
        bit ok;
        logic [NP-1:0] pend_seen;
        do_reset();
        wait_color(0, GREEN, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL gap_wait_ph0: no green, expected ph0 green"); end
        len = 0;
        pend_seen = '0;
        while (lamp(0) == GREEN && len < 100) begin
            if (len == 3) bus.ped_req[2] = 1'b1;
            if (len == 5) bus.ped_req[2] = 1'b0;
            if (len == 6) pend_seen = bus.ped_pending;
            len++;
            @(negedge clk);
        end
        n_checks++;
        if (pend_seen !== 3'b100) begin n_fail++; $display("FAIL gap_latched: got %b expected 100", pend_seen); end
        n_checks++;
        if (len != 10) begin n_fail++; $display("FAIL gap_ph0_green: got %0d expected 10", len); end
        seg(1, GREEN, len, wc, wl, ok);
        n_checks++;
        if (!ok || len != 10 || wc != 0) begin n_fail++; $display("FAIL gap_ph1_green: len %0d walk %0d expected 10/0", len, wc); end
        wait_color(2, GREEN, ok);
        n_checks++;
        if (!ok || bus.ped_pending[2] !== 1'b0 || bus.walk !== 3'b100) begin
            n_fail++; $display("FAIL gap_ph2_entry: pending %b walk %b expected 0xx/100", bus.ped_pending, bus.walk);
        end
        seg(2, GREEN, len, wc, wl, ok);
        n_checks++;
        if (!ok || len != 30 || wc != 4 || wl != 3) begin
            n_fail++; $display("FAIL gap_ph2_green: len %0d walk %0d last %0d expected 30/4/3", len, wc, wl);
        end
    endtask

    task automatic test_ped_held();
        int exp_ph [5] = '{0, 1, 2, 0, 1};
        int exp_len[5] = '{10, 30, 10, 10, 30};
        int exp_wc [5] = '{0, 4, 0, 0, 4};
        int len, wc, wl;
        bit ok;
        do_reset();
        bus.ped_req[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            seg(exp_ph[k], GREEN, len, wc, wl, ok);
            n_checks++;
            if (!ok || len != exp_len[k] || wc != exp_wc[k]) begin
                n_fail++; $display("FAIL held_green%0d ph%0d: len %0d walk %0d expected %0d/%0d",
                                   k, exp_ph[k], len, wc, exp_len[k], exp_wc[k]);
            end
        end
        bus.ped_req = '0;
    endtask

    task automatic test_preempt();
        int len, wc, wl, first;
        bit ok;
        do_reset();
        wait_color(0, GREEN, ok);
        len = 0;
        while (ok && lamp(0) == GREEN && len < 100) begin
            if (len == 3) begin bus.preempt = 1'b1; bus.preempt_phase = 2'd2; end
            len++;
            @(negedge clk);
        end
        n_checks++;
        if (!ok || len != 4) begin n_fail++; $display("FAIL pre_ph0_green: got %0d expected 4", len); end
        seg(0, YELLOW, len, wc, wl, ok);
        n_checks++;
        if (!ok || len != 5) begin n_fail++; $display("FAIL pre_ph0_yellow: got %0d expected 5", len); end
        count_allred(len);
        n_checks++;
        if (len != 5) begin n_fail++; $display("FAIL pre_allred: got %0d expected 5", len); end
        n_checks++;
        if (lamp(2) !== GREEN) begin n_fail++; $display("FAIL pre_ph2_entry: got %b expected 100", lamp(2)); end
        len = 0; wc = 0;
        while (lamp(2) == GREEN && len < 200) begin
            if (len == 20) bus.preempt = 1'b0;
            if (bus.walk != '0) wc++;
            len++;
            @(negedge clk);
        end
        n_checks++;
        if (len != 50 || wc != 0) begin n_fail++; $display("FAIL pre_ph2_green: len %0d walk %0d expected 50/0", len, wc); end
        first = -1;
        for (int i = 0; i < 300 && first < 0; i++) begin
            for (int p = 0; p < NP; p++) if (lamp(p) == GREEN) first = p;
            if (first < 0) @(negedge clk);
        end
        n_checks++;
        if (first != 0) begin n_fail++; $display("FAIL pre_resume: next green ph%0d expected ph0", first); end
    endtask

    task automatic test_reset_mid();
        int len, wc, wl;
        bit ok;
        do_reset();
        wait_color(1, YELLOW, ok);
        n_checks++;
        if (!ok || bus.active_phase !== 2'd1) begin n_fail++; $display("FAIL mid_reach_y1: active %0d expected 1", bus.active_phase); end
        bus.ped_req[2] = 1'b1;
        @(negedge clk);
        bus.ped_req[2] = 1'b0;
        n_checks++;
        if (bus.ped_pending !== 3'b100) begin n_fail++; $display("FAIL mid_pending_set: got %b expected 100", bus.ped_pending); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.light !== LAMPS_RED || bus.walk !== '0) begin
            n_fail++; $display("FAIL mid_async_lamps: light %b walk %b expected %b/000", bus.light, bus.walk, LAMPS_RED);
        end
        n_checks++;
        if (bus.ped_pending !== '0 || bus.active_phase !== '0) begin
            n_fail++; $display("FAIL mid_async_state: pending %b active %0d expected 0/0", bus.ped_pending, bus.active_phase);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_allred(len);
        n_checks++;
        if (len != 5) begin n_fail++; $display("FAIL mid_restart_ar: got %0d expected 5", len); end
        seg(0, GREEN, len, wc, wl, ok);
        n_checks++;
        if (!ok || len != 30) begin n_fail++; $display("FAIL mid_restart_green: got %0d expected 30", len); end
    endtask

    initial begin
        bus.ped_req = '0;
        bus.preempt = 1'b0;
        bus.preempt_phase = '0;
        test_reset();
        test_free_run();
        test_ped_gap();
        test_ped_held();
        test_preempt();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
